// File: rtl/battery_pkg.sv
// Shared types and sizing helpers for the battery level monitor.
// State encodings are visible on the state output, so they are fixed explicitly.
package battery_pkg;

  typedef enum logic [1:0] {
    StNormal = 2'b00,
    StLow    = 2'b01,
    StEmpty  = 2'b10
  } batt_state_e;

  // Counter width able to hold values 0..n-1; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blink_generator.sv
// Square-wave generator for the low-battery LED: starts high on the rising
// edge of en, toggles every BLINK_DIV cycles, held low while en is low.
module blink_generator
  import battery_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic blink
);

  localparam int unsigned CntW = cnt_width(BLINK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_q, blink_d;
  logic            en_q;

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!en) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (!en_q) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      en_q    <= en;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/battery_level_monitor.sv
// Classifies a battery level into NORMAL / LOW / EMPTY with hysteresis and a
// consecutive-sample debounce, driving the LEDs and a one-shot empty alarm.
module battery_level_monitor
  import battery_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EMPTY_TH  = 0,
  parameter int unsigned LOW_TH    = 3,
  parameter int unsigned HYST      = 1,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [1:0]       state,
  output logic             led_empty,
  output logic             led_low,
  output logic             alarm_pulse
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE + 1);

  // One extra bit so threshold + HYST can never wrap.
  localparam logic [WIDTH:0] EmptyTh   = (WIDTH + 1)'(EMPTY_TH);
  localparam logic [WIDTH:0] LowTh     = (WIDTH + 1)'(LOW_TH);
  localparam logic [WIDTH:0] EmptyHyst = (WIDTH + 1)'(EMPTY_TH + HYST);
  localparam logic [WIDTH:0] LowHyst   = (WIDTH + 1)'(LOW_TH + HYST);

  logic [WIDTH:0]  lvl;
  batt_state_e     state_q, state_d, cand_q, cand_d, target;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            led_empty_q, alarm_q;

  assign lvl = {1'b0, level};

  always_comb begin
    target = state_q;
    case (state_q)
      StNormal: begin
        if (lvl <= EmptyTh)    target = StEmpty;
        else if (lvl <= LowTh) target = StLow;
        else                   target = StNormal;
      end
      StLow: begin
        if (lvl <= EmptyTh)      target = StEmpty;
        else if (lvl > LowHyst)  target = StNormal;
        else                     target = StLow;
      end
      StEmpty: begin
        if (lvl > LowHyst)        target = StNormal;
        else if (lvl > EmptyHyst) target = StLow;
        else                      target = StEmpty;
      end
      default: target = StNormal;
    endcase
  end

  // Counter never exceeds DEBOUNCE-1 while held, so the increment cannot overflow.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cnt_inc = (target == cand_q) ? cnt_q + CntW'(1) : CntW'(1);
    if (target == state_q) begin
      cnt_d = '0;
    end else begin
      cand_d = target;
      if (cnt_inc == CntW'(DEBOUNCE)) begin
        state_d = target;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StNormal;
      cand_q      <= StNormal;
      cnt_q       <= '0;
      led_empty_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      led_empty_q <= (state_d == StEmpty);
      alarm_q     <= (state_d == StEmpty) && (state_q != StEmpty);
    end
  end

  // Fed from next state so led_low moves on the same edge as state.
  blink_generator #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_d == StLow),
    .blink(led_low)
  );

  always_comb begin
    state       = state_q;
    led_empty   = led_empty_q;
    alarm_pulse = alarm_q;
  end

endmodule
